prio_event_capture: RTL and testbench
=====================================

PRIO_EVENT_CAPTURE -- requirements
Module: prio_event_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the number of consecutive stable synchronized samples (legal range 2-255) required to accept a press or a release.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 y  input  3  SHALL carry the active-low encoded index from the upstream 8-to-3 priority encoder (111 = line 0, 000 = line 7).
REQ-005 gs  input  1  SHALL carry the active-low group-select from the encoder (0 = some line active).
REQ-006 code_ready  input  1  SHALL be the consumer's ready signal for the output handshake.
REQ-007 code  output  3  SHALL present the true index (~y) at the FIFO head.
REQ-008 code_valid  output  1  SHALL be high when the FIFO is non-empty.
REQ-009 fifo_count  output  3  SHALL show the FIFO occupancy (0-4).
REQ-010 overflow  output  1  SHALL be a sticky flag: an event was dropped because the FIFO was full.

Function
REQ-011 y and gs SHALL each pass through a 2-flop synchronizer (y_s, gs_s); the synchronizer flops SHALL reset to 1 (inactive).
REQ-012 FSM states SHALL be IDLE, QUALIFY, HELD and RELEASE, with a debounce counter cnt of 8 bits.
REQ-013 IDLE: gs_s=0 -> QUALIFY, with cnt=0 and cand=y_s latched; otherwise remain in IDLE.
REQ-014 QUALIFY: gs_s=1 or y_s!=cand -> IDLE; else cnt==DEBOUNCE_CYCLES-1 -> push ~cand into the FIFO and go to HELD; else cnt+1.
REQ-015 HELD: gs_s=1 -> RELEASE, with cnt=0; changes of y_s while in HELD SHALL be ignored (one event per press).
REQ-016 RELEASE: gs_s=0 -> HELD; cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-017 Latency: a clean press SHALL push on the (DEBOUNCE_CYCLES+3)th rising edge after the input change; code_valid SHALL rise immediately after that edge when the FIFO was empty.
REQ-018 The FIFO SHALL be 4 entries deep, first-in first-out, with 2-bit read/write pointers that wrap 3->0.
REQ-019 A pop SHALL occur on a rising edge when code_valid=1 and code_ready=1.
REQ-020 code SHALL be 000 when the FIFO is empty.
REQ-021 When the FIFO is full with push and no pop, the event SHALL be dropped and overflow SHALL be set to 1 until reset.
REQ-022 When the FIFO is full with push and pop in the same cycle, both SHALL occur, fifo_count SHALL stay 4, and overflow SHALL be unchanged.
REQ-023 When the FIFO is empty, a pop SHALL NOT occur (code_valid=0).
REQ-024 When the FIFO is non-empty with push and pop in the same cycle, fifo_count SHALL be unchanged.
REQ-025 code_ready SHALL NOT affect the FSM; events SHALL be captured regardless of back-pressure.

Reset
REQ-026 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, cnt=0, cand=000, pointers=0, fifo_count=0, code=000, code_valid=0, overflow=0, and synchronizer flops=1.
REQ-027 Reset asserted mid-QUALIFY or mid-HELD SHALL abandon the event; the FIFO contents SHALL be discarded.
REQ-028 After reset_n rises, an input that is still held SHALL be treated as a new press and SHALL be qualified from IDLE.

Verification
REQ-029 Reset, then gs=0, y=000 held, code_ready=0 -> code_valid rises after edge 7 (DEBOUNCE_CYCLES=4), code=111, fifo_count=1.
REQ-030 gs=0, y=101 for 2 cycles then gs=1 (glitch) -> no push, code_valid stays 0, FSM returns to IDLE.
REQ-031 Five clean presses with codes 0,1,2,3,4 (each followed by a clean release), code_ready=0 -> fifo_count=4, overflow=1; then popping yields code 0,1,2,3 in order and code_valid falls after the 4th pop.
REQ-032 During a held press, y changes 110 -> 011 while gs stays 0 -> exactly one event with code=001 is pushed.
REQ-033 FIFO full, code_ready=1, and a press completes on the same edge as a pop -> fifo_count stays 4, overflow stays 0, and the new code is the last entry read out.
REQ-034 reset_n pulsed low for 3 ns mid-QUALIFY, between clock edges -> all outputs go to 0 asynchronously, and no event is pushed from the abandoned press.

Source files
------------

// File: rtl/prio_event_capture.sv
// Debounced capture of priority-encoder key events into a 4-deep code FIFO.
// The encoder outputs are synchronized, qualified by a press/release FSM and queued for a ready/valid consumer.
module prio_event_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] y,
  input  logic       gs,
  input  logic       code_ready,
  output logic [2:0] code,
  output logic       code_valid,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [2:0] r_y_meta;
  logic [2:0] r_y_s;
  logic       r_gs_meta;
  logic       r_gs_s;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [2:0] r_cand;
  logic [2:0] w_cand_nxt;
  logic       w_push;
  logic [2:0] w_push_code;

  logic [2:0] r_mem [4];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_count;
  logic [2:0] r_code;
  logic       r_code_valid;
  logic       r_overflow;

  logic       w_pop;
  logic       w_full;
  logic       w_accept;
  logic       w_drop;
  logic [1:0] w_rd_nxt;
  logic [2:0] w_count_nxt;
  logic [2:0] w_code_nxt;

  // Two-flop synchronizers; reset to the encoder's idle levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y_meta  <= 3'b111;
      r_y_s     <= 3'b111;
      r_gs_meta <= 1'b1;
      r_gs_s    <= 1'b1;
    end else begin
      r_y_meta  <= y;
      r_y_s     <= r_y_meta;
      r_gs_meta <= gs;
      r_gs_s    <= r_gs_meta;
    end
  end

  // Debounce FSM state, counter and candidate index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_cand  <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Next-state logic: one push per qualified press, held code changes ignored
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_gs_s) begin
          w_state_nxt = S_QUALIFY;
          w_cnt_nxt   = 8'd0;
          w_cand_nxt  = r_y_s;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_QUALIFY: begin
        if (r_gs_s || (r_y_s != r_cand)) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_push      = 1'b1;
          w_state_nxt = S_HELD;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_HELD: begin
        if (r_gs_s) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = S_HELD;
        end
      end
      S_RELEASE: begin
        if (!r_gs_s) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
        w_cand_nxt  = 3'b000;
      end
    endcase
  end

  assign w_push_code = ~r_cand;

  // FIFO control; the head code is precomputed so outputs come straight from flops
  always_comb begin
    w_pop    = r_code_valid & code_ready;
    w_full   = (r_count == 3'd4);
    w_accept = w_push & (~w_full | w_pop);
    w_drop   = w_push & w_full & ~w_pop;
    if (w_pop) begin
      w_rd_nxt = r_rd_ptr + 2'd1;
    end else begin
      w_rd_nxt = r_rd_ptr;
    end
    if (w_accept && !w_pop) begin
      w_count_nxt = r_count + 3'd1;
    end else if (!w_accept && w_pop) begin
      w_count_nxt = r_count - 3'd1;
    end else begin
      w_count_nxt = r_count;
    end
    if (w_count_nxt == 3'd0) begin
      w_code_nxt = 3'b000;
    end else if (w_accept && (r_wr_ptr == w_rd_nxt)) begin
      w_code_nxt = w_push_code;
    end else begin
      w_code_nxt = r_mem[w_rd_nxt];
    end
  end

  // FIFO storage, pointers, registered outputs and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 3'b000;
      end
      r_rd_ptr     <= 2'd0;
      r_wr_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_code       <= 3'b000;
      r_code_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_push_code;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_rd_ptr     <= w_rd_nxt;
      r_count      <= w_count_nxt;
      r_code       <= w_code_nxt;
      r_code_valid <= (w_count_nxt != 3'd0);
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_prio_event_capture.sv
// Randomized and directed bench for prio_event_capture against a sample-counting reference model.
module tb_prio_event_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] y;
  logic       gs;
  logic       code_ready;
  logic [2:0] code;
  logic       code_valid;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  // reference model: synchronizer pipeline as {gs,y}, press/release sample runs, FIFO queue
  logic [3:0] m_s1, m_s2;
  bit         m_armed;
  int         m_run, m_rel;
  logic [2:0] m_y;
  logic [2:0] m_q[$];
  bit         m_ovf;

  always #5 clk = ~clk;

  prio_event_capture #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .y          (y),
    .gs         (gs),
    .code_ready (code_ready),
    .code       (code),
    .code_valid (code_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1    = 4'hF;
    m_s2    = 4'hF;
    m_armed = 1'b1;
    m_run   = 0;
    m_rel   = 0;
    m_y     = 3'd0;
    m_q.delete();
    m_ovf   = 1'b0;
  endtask

  // A press is accepted after D+1 consecutive armed samples with gs low and the same index;
  // re-arming needs D+1 consecutive samples with gs high.
  task automatic model_edge();
    bit         push, pop, sg;
    logic [2:0] sy, pv;
    push = 1'b0;
    pv   = 3'd0;
    pop  = (m_q.size() != 0) && code_ready;
    sg   = m_s2[3];
    sy   = m_s2[2:0];
    if (m_armed) begin
      if (m_run == 0) begin
        if (!sg) begin
          m_run = 1;
          m_y   = sy;
        end
      end else if (sg || sy != m_y) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == D + 1) begin
          push    = 1'b1;
          pv      = ~m_y;
          m_armed = 1'b0;
          m_rel   = 0;
        end
      end
    end else begin
      if (sg) m_rel++;
      else m_rel = 0;
      if (m_rel == D + 1) begin
        m_armed = 1'b1;
        m_run   = 0;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 4) m_q.push_back(pv);
      else m_ovf = 1'b1;
    end
    m_s2 = m_s1;
    m_s1 = {gs, y};
  endtask

  task automatic compare_all();
    logic [2:0] exp_code;
    exp_code = (m_q.size() != 0) ? m_q[0] : 3'd0;
    check_val("code_valid", 8'(code_valid), 8'(m_q.size() != 0));
    check_val("code", 8'(code), 8'(exp_code));
    check_val("fifo_count", 8'(fifo_count), 8'(m_q.size()));
    check_val("overflow", 8'(overflow), 8'(m_ovf));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_code"}, 8'(code), 8'd0);
    check_val({tag, "_valid"}, 8'(code_valid), 8'd0);
    check_val({tag, "_count"}, 8'(fifo_count), 8'd0);
    check_val({tag, "_ovf"}, 8'(overflow), 8'd0);
  endtask

  // called in the low clock phase; the 3 ns pulse ends before the next rising edge
  task automatic reset_pulse();
    #1 reset_n = 1'b0;
    #1 check_zero("async_rst");
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [2:0] c, input int hold, input int rel);
    gs = 1'b0;
    y  = ~c;
    tick(hold);
    gs = 1'b1;
    y  = 3'b111;
    tick(rel);
  endtask

  initial begin
    reset_n    = 1'b0;
    gs         = 1'b1;
    y          = 3'b111;
    code_ready = 1'b0;
    model_reset();
    #1 check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // clean press of line 7: push on the 7th edge
    gs = 1'b0;
    y  = 3'b000;
    tick(6);
    check_val("lat_before", 8'(code_valid), 8'd0);
    tick(1);
    check_val("lat_valid", 8'(code_valid), 8'd1);
    check_val("lat_code", 8'(code), 8'd7);
    check_val("lat_count", 8'(fifo_count), 8'd1);
    gs = 1'b1;
    y  = 3'b111;
    tick(8);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;

    // short glitch is rejected
    gs = 1'b0;
    y  = 3'b101;
    tick(2);
    gs = 1'b1;
    y  = 3'b111;
    tick(10);
    check_val("glitch_valid", 8'(code_valid), 8'd0);

    // five presses into a 4-deep FIFO with no consumer
    for (int c = 0; c < 5; c++) press(3'(c), 8, 8);
    check_val("full_count", 8'(fifo_count), 8'd4);
    check_val("full_ovf", 8'(overflow), 8'd1);
    code_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check_val("pop_order", 8'(code), 8'(c));
      tick(1);
    end
    code_ready = 1'b0;
    check_val("drained_valid", 8'(code_valid), 8'd0);
    check_val("ovf_sticky", 8'(overflow), 8'd1);

    // push and pop on the same edge while full
    reset_pulse();
    press(3'd5, 8, 8);
    press(3'd6, 8, 8);
    press(3'd7, 8, 8);
    press(3'd2, 8, 8);
    gs = 1'b0;
    y  = ~3'd3;
    tick(6);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    check_val("pp_count", 8'(fifo_count), 8'd4);
    check_val("pp_ovf", 8'(overflow), 8'd0);
    gs = 1'b1;
    y  = 3'b111;
    tick(8);
    code_ready = 1'b1;
    check_val("pp_head", 8'(code), 8'd6);
    tick(3);
    check_val("pp_last", 8'(code), 8'd3);
    tick(1);
    code_ready = 1'b0;

    // index change during a held press yields a single event
    gs = 1'b0;
    y  = 3'b110;
    tick(8);
    y  = 3'b011;
    tick(8);
    gs = 1'b1;
    y  = 3'b111;
    tick(8);
    check_val("held_count", 8'(fifo_count), 8'd1);
    check_val("held_code", 8'(code), 8'd1);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;

    // reset mid-qualify abandons the press
    gs = 1'b0;
    y  = 3'b100;
    tick(4);
    reset_pulse();
    gs = 1'b1;
    y  = 3'b111;
    tick(12);
    check_val("abandon_valid", 8'(code_valid), 8'd0);

    // still-held input after reset is a fresh press
    gs = 1'b0;
    y  = 3'b010;
    tick(5);
    reset_pulse();
    tick(10);
    check_val("rehold_count", 8'(fifo_count), 8'd1);
    check_val("rehold_code", 8'(code), 8'd5);
    gs = 1'b1;
    y  = 3'b111;
    tick(8);

    // randomized segments with random back-pressure and rare resets
    for (int s = 0; s < 400; s++) begin
      int len;
      len = $urandom_range(1, 12);
      gs  = 1'($urandom_range(0, 1));
      y   = 3'($urandom_range(0, 7));
      for (int k = 0; k < len; k++) begin
        code_ready = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) == 0) y = 3'($urandom_range(0, 7));
        tick(1);
      end
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
